// File: rtl/des_pkg.sv
// Shared DES definitions: FSM state, permutation/S-box/shift tables, permute helpers.
// Used by encrypt, decrypt and des_f.
package des_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} state_t;

  // Tables use DES numbering: entry j names the 1-based source bit for output bit j+1.
  localparam int unsigned IP_T [64] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};

  localparam int unsigned FP_T [64] = '{
    40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
    34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};

  localparam int unsigned E_T [48] = '{
    32,1,2,3,4,5,     4,5,6,7,8,9,     8,9,10,11,12,13,  12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};

  localparam int unsigned P_T [32] = '{
    16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};

  localparam int unsigned PC1_T [56] = '{
    57,49,41,33,25,17,9,1,  58,50,42,34,26,18,10,2,
    59,51,43,35,27,19,11,3, 60,52,44,36,
    63,55,47,39,31,23,15,7, 62,54,46,38,30,22,14,6,
    61,53,45,37,29,21,13,5, 28,20,12,4};

  localparam int unsigned PC2_T [48] = '{
    14,17,11,24,1,5,  3,28,15,6,21,10,  23,19,12,4,26,8,  16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

  localparam int unsigned SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // S-boxes flattened as row*16 + column.
  localparam int unsigned SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // DES bit n of a W-bit vector lives at index W-n (bit 1 is the MSB).
  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - IP_T[j])];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - FP_T[j])];
    return y;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] y;
    for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[5'(32 - E_T[j])];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    for (int j = 0; j < 32; j++) y[5'(31 - j)] = x[5'(32 - P_T[j])];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    for (int j = 0; j < 56; j++) y[6'(55 - j)] = x[6'(64 - PC1_T[j])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[6'(56 - PC2_T[j])];
    return y;
  endfunction

endpackage

// File: rtl/des_f.sv
// DES round function f(R,K): expand, key-mix, S-box substitution, P permutation.
module des_f
  import des_pkg::*;
(
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] f_c
);

  logic [47:0] mix;
  logic [31:0] sub;
  logic [5:0]  six;

  // Eight 6->4 lookups; row from outer bits, column from inner four.
  always_comb begin
    mix = e_expand(r) ^ k;
    sub = '0;
    six = '0;
    for (int i = 0; i < 8; i++) begin
      six = mix[6'(42 - 6 * i) +: 6];
      sub[5'(28 - 4 * i) +: 4] = 4'(SBOX[3'(i)][6'({six[5], six[0], six[4:1]})]);
    end
    f_c = p_perm(sub);
  end

endmodule

// File: rtl/encrypt.sv
// Iterative DES encryption, one Feistel round per clock, done/ack handshake.
// Optional: DES_KEY_PARITY_CHECK_EN adds key_err and rejects keys with even-parity bytes.
module encrypt
  import des_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0][7:0] message,
  input  logic [7:0][7:0] DESkey,
  output logic [7:0][7:0] encrypted,
  output logic            done,
  input  logic            enable,
  input  logic            ack
`ifdef DES_KEY_PARITY_CHECK_EN
  ,
  output logic            key_err
`endif
);

  localparam int unsigned CNT_W = $clog2(NUM_ROUNDS + 1);

  state_t           state;
  logic [CNT_W-1:0] round_cnt;
  logic [31:0]      l_q, r_q;
  logic [27:0]      c_q, d_q;
  logic [27:0]      c_rot, d_rot;
  logic [47:0]      k_rnd;
  logic [31:0]      f_c;
  logic [63:0]      ip_msg;
  logic [55:0]      pc1_key;

  // Key schedule rotation for the current round and input permutations.
  always_comb begin
    if (SHIFTS[4'(round_cnt)] == 2) begin
      c_rot = {c_q[25:0], c_q[27:26]};
      d_rot = {d_q[25:0], d_q[27:26]};
    end else begin
      c_rot = {c_q[26:0], c_q[27]};
      d_rot = {d_q[26:0], d_q[27]};
    end
    k_rnd   = pc2_perm({c_rot, d_rot});
    ip_msg  = ip_perm(message);
    pc1_key = pc1_perm(DESkey);
  end

  des_f u_f (
    .r   (r_q),
    .k   (k_rnd),
    .f_c (f_c)
  );

`ifdef DES_KEY_PARITY_CHECK_EN
  logic key_par_ok;

  // Every key byte must carry odd parity.
  always_comb begin
    key_par_ok = 1'b1;
    for (int i = 0; i < 8; i++) key_par_ok = key_par_ok & (^DESkey[i]);
  end
`endif

  // Control FSM and round datapath; the extra ROUND cycle after the last round
  // applies the final swap and FP into the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      round_cnt <= '0;
      l_q       <= '0;
      r_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      encrypted <= '0;
      done      <= 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
      key_err   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
`ifdef DES_KEY_PARITY_CHECK_EN
            if (!key_par_ok) begin
              encrypted <= '0;
              done      <= 1'b1;
              key_err   <= 1'b1;
              state     <= ST_DONE;
            end else
`endif
            begin
              l_q       <= ip_msg[63:32];
              r_q       <= ip_msg[31:0];
              c_q       <= pc1_key[55:28];
              d_q       <= pc1_key[27:0];
              round_cnt <= '0;
              state     <= ST_ROUND;
            end
          end
        end
        ST_ROUND: begin
          if (round_cnt == CNT_W'(NUM_ROUNDS)) begin
            encrypted <= fp_perm({r_q, l_q});
            done      <= 1'b1;
            state     <= ST_DONE;
          end else begin
            c_q       <= c_rot;
            d_q       <= d_rot;
            l_q       <= r_q;
            r_q       <= l_q ^ f_c;
            round_cnt <= round_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (ack) begin
            done  <= 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
            key_err <= 1'b0;
`endif
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encrypt.sv
// Directed bench for encrypt: known answers, latency, handshake, ignored inputs, reset abort.
module tb_encrypt;

  localparam logic [63:0] KAT_KEY  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KAT_MSG  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KAT_CT   = 64'h85E813540F0AB405;
  localparam logic [63:0] ZERO_CT  = 64'h8CA64DE9C1B123A7;
  localparam logic [63:0] V3_KEY   = 64'h0E329232EA6D0D73;
  localparam logic [63:0] V3_MSG   = 64'h8787878787878787;
  localparam logic [63:0] V3_CT    = 64'h0000000000000000;

  logic            clk_tb = 1'b0;
  logic            reset;
  logic [7:0][7:0] message;
  logic [7:0][7:0] des_key;
  logic [7:0][7:0] encrypted;
  logic            done;
  logic            enable;
  logic            ack;
`ifdef DES_KEY_PARITY_CHECK_EN
  logic            key_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_tb = ~clk_tb;

  encrypt dut (
    .clk       (clk_tb),
    .reset     (reset),
    .message   (message),
    .DESkey    (des_key),
    .encrypted (encrypted),
    .done      (done),
    .enable    (enable),
    .ack       (ack)
`ifdef DES_KEY_PARITY_CHECK_EN
    ,
    .key_err   (key_err)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    ack     = 1'b0;
    message = '0;
    des_key = '0;
    repeat (2) @(negedge clk_tb);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_enc", encrypted, 64'd0);
    reset = 1'b0;

    // Known answer with exact 17-cycle latency
    message = KAT_MSG; des_key = KAT_KEY; enable = 1'b1;
    @(negedge clk_tb); enable = 1'b0;
    repeat (16) @(negedge clk_tb);
    chk("kat_not_early", 64'(done), 64'd0);
    @(negedge clk_tb);
    chk("kat_done", 64'(done), 64'd1);
    chk("kat_ct", encrypted, KAT_CT);

    // Done held without ack
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_tb);
      chk("hold_done", 64'(done), 64'd1);
      chk("hold_ct", encrypted, KAT_CT);
    end

    // ack together with enable: back to IDLE, no new run
    ack = 1'b1; enable = 1'b1;
    @(negedge clk_tb); ack = 1'b0; enable = 1'b0;
    chk("ack_done", 64'(done), 64'd0);
    chk("ack_ct_kept", encrypted, KAT_CT);
    repeat (20) @(negedge clk_tb);
    chk("no_restart", 64'(done), 64'd0);

    // All-zero key and message
    message = '0; des_key = '0; enable = 1'b1;
    @(negedge clk_tb); enable = 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
    chk("zero_perr_done", 64'(done), 64'd1);
    chk("zero_perr_flag", 64'(key_err), 64'd1);
    chk("zero_perr_ct", encrypted, 64'd0);
`else
    repeat (16) @(negedge clk_tb);
    chk("zero_not_early", 64'(done), 64'd0);
    @(negedge clk_tb);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_ct", encrypted, ZERO_CT);
`endif
    ack = 1'b1;
    @(negedge clk_tb); ack = 1'b0;
    chk("zero_ack", 64'(done), 64'd0);
`ifdef DES_KEY_PARITY_CHECK_EN
    chk("zero_flag_clr", 64'(key_err), 64'd0);
`endif

    // Second known answer, restarted right after the ack
    message = V3_MSG; des_key = V3_KEY; enable = 1'b1;
    @(negedge clk_tb); enable = 1'b0;
    repeat (16) @(negedge clk_tb);
    chk("v3_not_early", 64'(done), 64'd0);
    @(negedge clk_tb);
    chk("v3_done", 64'(done), 64'd1);
    chk("v3_ct", encrypted, V3_CT);
    ack = 1'b1;
    @(negedge clk_tb); ack = 1'b0;

    // Inputs changed and enable/ack pulsed mid-run have no effect
    message = KAT_MSG; des_key = KAT_KEY; enable = 1'b1;
    @(negedge clk_tb); enable = 1'b0;
    repeat (7) @(negedge clk_tb);
    message = ~KAT_MSG; des_key = V3_KEY; enable = 1'b1; ack = 1'b1;
    @(negedge clk_tb); enable = 1'b0; ack = 1'b0;
    repeat (8) @(negedge clk_tb);
    chk("ign_not_early", 64'(done), 64'd0);
    @(negedge clk_tb);
    chk("ign_done", 64'(done), 64'd1);
    chk("ign_ct", encrypted, KAT_CT);
    ack = 1'b1;
    @(negedge clk_tb); ack = 1'b0;

    // Reset at round 5 aborts and clears outputs
    enable = 1'b1;
    @(negedge clk_tb); enable = 1'b0;
    repeat (4) @(negedge clk_tb);
    reset = 1'b1;
    @(negedge clk_tb); reset = 1'b0;
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_ct", encrypted, 64'd0);
    repeat (20) @(negedge clk_tb);
    chk("mid_rst_idle", 64'(done), 64'd0);

    // Fresh start after reset
    message = KAT_MSG; des_key = KAT_KEY; enable = 1'b1;
    @(negedge clk_tb); enable = 1'b0;
    repeat (16) @(negedge clk_tb);
    chk("fresh_not_early", 64'(done), 64'd0);
    @(negedge clk_tb);
    chk("fresh_done", 64'(done), 64'd1);
    chk("fresh_ct", encrypted, KAT_CT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
